// File: rtl/ysyx_2022040010_regfile_pkg.sv
// Shared types and helpers for the 32 x 64-bit register file and its
// pending-write scoreboard. The write-back bus layout comes from the shared defines.
`ifndef BP_TO_RF_BUS
`define BP_TO_RF_BUS 70
`define RF_WE_POS    69
`define RF_WADDR_HI  68
`define RF_WADDR_LO  64
`define RF_WDATA_HI  63
`define RF_WDATA_LO  0
`endif

package ysyx_2022040010_regfile_pkg;

  localparam int XLEN = 64;
  localparam int AW   = 5;
  localparam int NREG = 32;

  typedef struct packed {
    logic            we;
    logic [AW-1:0]   waddr;
    logic [XLEN-1:0] wdata;
  } wb_req_t;

  function automatic wb_req_t unpack_wb(input logic [`BP_TO_RF_BUS-1:0] bus);
    wb_req_t req;
    req.we    = bus[`RF_WE_POS];
    req.waddr = bus[`RF_WADDR_HI:`RF_WADDR_LO];
    req.wdata = bus[`RF_WDATA_HI:`RF_WDATA_LO];
    return req;
  endfunction

  // One-hot register select; x0 never appears because it has no counter.
  function automatic logic [NREG-1:0] addr_onehot(input logic en, input logic [AW-1:0] a);
    logic [NREG-1:0] oh;
    oh = '0;
    if (en && (a != '0)) oh[a] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/ysyx_2022040010_rf_scoreboard.sv
// Per-register pending-write counters: an issue bumps the destination count, a
// write-back retires one. Drives the busy/full stall signals and a sticky error.
module ysyx_2022040010_rf_scoreboard
  import ysyx_2022040010_regfile_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_waddr,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_rd,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  output logic          busy1,
  output logic          busy2,
  output logic          issue_full,
  output logic          sb_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt     [NREG];
  logic [CNT_W-1:0] cnt_nxt [NREG];
  logic [NREG-1:0]  wb_hit;
  logic [NREG-1:0]  iss_hit;
  logic             err_q;
  logic             err_nxt;

  assign wb_hit  = addr_onehot(wb_we, wb_waddr);
  assign iss_hit = addr_onehot(issue_valid, issue_rd);

  // Issue and write-back to the same register in one cycle cancel out.
  always_comb begin
    err_nxt = err_q;
    for (int r = 0; r < NREG; r++) begin
      cnt_nxt[r] = cnt[r];
      if (r == 0) begin
        cnt_nxt[r] = '0;
      end else if (iss_hit[r] && !wb_hit[r]) begin
        if (cnt[r] != CNT_MAX) cnt_nxt[r] = cnt[r] + CNT_ONE;
      end else if (wb_hit[r] && !iss_hit[r]) begin
        if (cnt[r] != '0) cnt_nxt[r] = cnt[r] - CNT_ONE;
        else              err_nxt    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt[r] <= cnt_nxt[r];
      err_q <= err_nxt;
    end
  end

  // A write-back that retires the last outstanding producer frees the register now.
  function automatic logic reg_busy(input logic [AW-1:0] a);
    logic retiring;
    retiring = wb_hit[a] && !iss_hit[a] && (cnt[a] == CNT_ONE);
    return (a != '0) && (cnt[a] != '0) && !retiring;
  endfunction

  assign busy1      = reg_busy(raddr1);
  assign busy2      = reg_busy(raddr2);
  assign issue_full = (issue_rd != '0) && (cnt[issue_rd] == CNT_MAX) && !wb_hit[issue_rd];
  assign sb_err     = err_q;

endmodule

// File: rtl/ysyx_2022040010_regfile.sv
// 32 x 64-bit register file with x0 hard-wired to zero, same-cycle write-back
// bypass on both read ports, and a pending-write scoreboard for decode stalls.
module ysyx_2022040010_regfile
  import ysyx_2022040010_regfile_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [`BP_TO_RF_BUS-1:0] wb_to_rf_bus,
  input  logic [4:0]               raddr1,
  output logic [63:0]              rdata1,
  input  logic [4:0]               raddr2,
  output logic [63:0]              rdata2,
  input  logic                     issue_valid,
  input  logic [4:0]               issue_rd,
  output logic                     busy1,
  output logic                     busy2,
  output logic                     issue_full,
  output logic                     sb_err
);

  wb_req_t         wb;
  logic [XLEN-1:0] regs [NREG];
  logic            wb_write;

  assign wb       = unpack_wb(wb_to_rf_bus);
  assign wb_write = wb.we && (wb.waddr != '0);

  // regs[0] is cleared at reset and never written, so x0 stays zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else if (wb_write) begin
      regs[wb.waddr] <= wb.wdata;
    end
  end

  function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] a);
    if (a == '0)                        return '0;
    else if (wb_write && wb.waddr == a) return wb.wdata;
    else                                return regs[a];
  endfunction

  assign rdata1 = read_port(raddr1);
  assign rdata2 = read_port(raddr2);

  ysyx_2022040010_rf_scoreboard #(
    .CNT_W(CNT_W)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .wb_we      (wb.we),
    .wb_waddr   (wb.waddr),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .raddr1     (raddr1),
    .raddr2     (raddr2),
    .busy1      (busy1),
    .busy2      (busy2),
    .issue_full (issue_full),
    .sb_err     (sb_err)
  );

endmodule

// File: tb/tb_ysyx_2022040010_regfile.sv
// Bench for ysyx_2022040010_regfile: directed scenarios plus a randomized run
// against a behavioural register/counter model.
module tb_ysyx_2022040010_regfile;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [63:0] wdata;
  logic [4:0]  raddr1, raddr2, issue_rd;
  logic        issue_valid;
  logic [63:0] rdata1, rdata2;
  logic        busy1, busy2, issue_full, sb_err;
  logic [69:0] wb_to_rf_bus;

  assign wb_to_rf_bus = {we, waddr, wdata};

  ysyx_2022040010_regfile #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .wb_to_rf_bus(wb_to_rf_bus),
    .raddr1      (raddr1),
    .rdata1      (rdata1),
    .raddr2      (raddr2),
    .rdata2      (rdata2),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .busy1       (busy1),
    .busy2       (busy2),
    .issue_full  (issue_full),
    .sb_err      (sb_err)
  );

  int vectors = 0;
  int miscompares = 0;

  // reference model: architectural values, outstanding producer counts, error flag
  logic [63:0] m_regs [32];
  int          m_cnt  [32];
  bit          m_err;

  function automatic int next_cnt(input int r);
    bit i, w;
    i = issue_valid && (int'(issue_rd) == r) && (r != 0);
    w = we && (int'(waddr) == r) && (r != 0);
    if (i && !w) return (m_cnt[r] >= CNT_MAX) ? CNT_MAX : m_cnt[r] + 1;
    if (w && !i) return (m_cnt[r] > 0) ? m_cnt[r] - 1 : 0;
    return m_cnt[r];
  endfunction

  function automatic logic [63:0] exp_rdata(input logic [4:0] a);
    if (a == 5'd0) return 64'd0;
    if (we && waddr == a) return wdata;
    return m_regs[a];
  endfunction

  function automatic bit exp_busy(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    return (m_cnt[a] > 0) && (next_cnt(int'(a)) > 0);
  endfunction

  function automatic bit exp_full();
    if (issue_rd == 5'd0) return 1'b0;
    return (m_cnt[issue_rd] == CNT_MAX) && !(we && waddr == issue_rd);
  endfunction

  // driver tasks
  task automatic set_idle();
    rst = 1'b0; we = 1'b0; waddr = 5'd0; wdata = 64'd0;
    raddr1 = 5'd0; raddr2 = 5'd0; issue_valid = 1'b0; issue_rd = 5'd0;
  endtask

  // Advance the model with the current inputs, then let the DUT see the edge.
  task automatic tick();
    int nc [32];
    bit ne;
    ne = m_err;
    if (rst) begin
      for (int r = 0; r < 32; r++) begin m_regs[r] = 64'd0; m_cnt[r] = 0; end
      ne = 1'b0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        nc[r] = next_cnt(r);
        if (we && int'(waddr) == r && !(issue_valid && int'(issue_rd) == r) && m_cnt[r] == 0)
          ne = 1'b1;
      end
      for (int r = 1; r < 32; r++) m_cnt[r] = nc[r];
      if (we && waddr != 5'd0) m_regs[waddr] = wdata;
    end
    m_err = ne;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    set_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    for (int k = 0; k < 4; k++) begin
      raddr1 = 5'($urandom_range(0, 31));
      raddr2 = 5'($urandom_range(0, 31));
      issue_rd = 5'($urandom_range(1, 31));
      #1;
      vectors++;
      if (rdata1 !== 64'd0 || rdata2 !== 64'd0) begin
        miscompares++;
        $display("FAIL reset_rdata: rdata1=%h rdata2=%h expected 0", rdata1, rdata2);
      end
      vectors++;
      if ({busy1, busy2, issue_full, sb_err} !== 4'b0000) begin
        miscompares++;
        $display("FAIL reset_flags: busy1/busy2/full/err=%b expected 0000",
                 {busy1, busy2, issue_full, sb_err});
      end
    end
  endtask

  task automatic test_bypass();
    reset_dut();
    we = 1'b1; waddr = 5'd5; wdata = 64'h1234_5678_9ABC_DEF0; raddr1 = 5'd5;
    #1;
    vectors++;
    if (rdata1 !== 64'h1234_5678_9ABC_DEF0) begin
      miscompares++;
      $display("FAIL bypass_same_cycle: rdata1=%h expected 123456789abcdef0", rdata1);
    end
    tick();
    we = 1'b0; wdata = 64'd0;
    #1;
    vectors++;
    if (rdata1 !== 64'h1234_5678_9ABC_DEF0) begin
      miscompares++;
      $display("FAIL bypass_next_cycle: rdata1=%h expected 123456789abcdef0", rdata1);
    end
  endtask

  task automatic test_x0();
    reset_dut();
    we = 1'b1; waddr = 5'd0; wdata = 64'hFFFF_FFFF_FFFF_FFFF; raddr2 = 5'd0;
    issue_valid = 1'b1; issue_rd = 5'd0;
    #1;
    vectors++;
    if (rdata2 !== 64'd0 || busy2 !== 1'b0 || issue_full !== 1'b0) begin
      miscompares++;
      $display("FAIL x0_bypass: rdata2=%h busy2=%b full=%b expected 0/0/0", rdata2, busy2, issue_full);
    end
    tick();
    set_idle();
    #1;
    vectors++;
    if (rdata2 !== 64'd0 || sb_err !== 1'b0) begin
      miscompares++;
      $display("FAIL x0_read: rdata2=%h sb_err=%b expected 0/0", rdata2, sb_err);
    end
  endtask

  task automatic test_saturate();
    reset_dut();
    raddr1 = 5'd7; issue_rd = 5'd7;
    for (int k = 0; k < 3; k++) begin issue_valid = 1'b1; tick(); end
    issue_valid = 1'b0;
    #1;
    vectors++;
    if (issue_full !== 1'b1 || busy1 !== 1'b1) begin
      miscompares++;
      $display("FAIL sat_full: full=%b busy1=%b expected 1/1", issue_full, busy1);
    end
    issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      we = 1'b1; waddr = 5'd7; wdata = 64'($urandom);
      #1;
      vectors++;
      if (busy1 !== (k != 2)) begin
        miscompares++;
        $display("FAIL sat_wb%0d_busy1: busy1=%b expected %b", k, busy1, k != 2);
      end
      vectors++;
      if (issue_full !== 1'b0) begin
        miscompares++;
        $display("FAIL sat_wb%0d_full: full=%b expected 0", k, issue_full);
      end
      tick();
    end
    we = 1'b0;
    #1;
    vectors++;
    if (busy1 !== 1'b0 || sb_err !== 1'b0) begin
      miscompares++;
      $display("FAIL sat_drained: busy1=%b sb_err=%b expected 0/0", busy1, sb_err);
    end
  endtask

  task automatic test_issue_wb_same();
    reset_dut();
    issue_valid = 1'b1; issue_rd = 5'd9; raddr1 = 5'd9;
    tick();
    we = 1'b1; waddr = 5'd9; wdata = 64'h99;
    #1;
    vectors++;
    if (busy1 !== 1'b1) begin
      miscompares++;
      $display("FAIL same_cycle_busy: busy1=%b expected 1", busy1);
    end
    tick();
    set_idle(); raddr1 = 5'd9;
    #1;
    vectors++;
    if (busy1 !== 1'b1 || sb_err !== 1'b0 || rdata1 !== 64'h99) begin
      miscompares++;
      $display("FAIL same_cycle_after: busy1=%b sb_err=%b rdata1=%h expected 1/0/99", busy1, sb_err, rdata1);
    end
    we = 1'b1; waddr = 5'd9; wdata = 64'h100;
    #1;
    vectors++;
    if (busy1 !== 1'b0) begin
      miscompares++;
      $display("FAIL same_cycle_retire: busy1=%b expected 0", busy1);
    end
    tick();
    we = 1'b0;
    #1;
    vectors++;
    if (sb_err !== 1'b0) begin
      miscompares++;
      $display("FAIL same_cycle_err: sb_err=%b expected 0", sb_err);
    end
  endtask

  task automatic test_err_sticky();
    logic [63:0] d;
    reset_dut();
    d = {32'($urandom), 32'($urandom)};
    we = 1'b1; waddr = 5'd3; wdata = d; raddr2 = 5'd3;
    #1;
    vectors++;
    if (sb_err !== 1'b0 || rdata2 !== d) begin
      miscompares++;
      $display("FAIL err_before_edge: sb_err=%b rdata2=%h expected 0/%h", sb_err, rdata2, d);
    end
    tick();
    we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      vectors++;
      if (sb_err !== 1'b1 || rdata2 !== d) begin
        miscompares++;
        $display("FAIL err_sticky%0d: sb_err=%b rdata2=%h expected 1/%h", k, sb_err, rdata2, d);
      end
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    vectors++;
    if (sb_err !== 1'b0 || rdata2 !== 64'd0) begin
      miscompares++;
      $display("FAIL err_cleared: sb_err=%b rdata2=%h expected 0/0", sb_err, rdata2);
    end
  endtask

  task automatic test_reset_priority();
    reset_dut();
    issue_valid = 1'b1; issue_rd = 5'd4; raddr1 = 5'd4;
    tick();
    issue_valid = 1'b0;
    #1;
    vectors++;
    if (busy1 !== 1'b1) begin
      miscompares++;
      $display("FAIL rstprio_busy_before: busy1=%b expected 1", busy1);
    end
    rst = 1'b1; we = 1'b1; waddr = 5'd4; wdata = 64'hAA; issue_valid = 1'b1;
    tick();
    set_idle(); raddr1 = 5'd4;
    #1;
    vectors++;
    if (rdata1 !== 64'd0 || busy1 !== 1'b0 || sb_err !== 1'b0) begin
      miscompares++;
      $display("FAIL rstprio_after: rdata1=%h busy1=%b sb_err=%b expected 0/0/0", rdata1, busy1, sb_err);
    end
  endtask

  task automatic test_random();
    reset_dut();
    for (int n = 0; n < 400; n++) begin
      rst         = ($urandom_range(0, 59) == 0);
      we          = ($urandom_range(0, 2) != 0);
      waddr       = 5'($urandom_range(0, 7));
      wdata       = {32'($urandom), 32'($urandom)};
      issue_valid = ($urandom_range(0, 1) != 0);
      issue_rd    = 5'($urandom_range(0, 7));
      raddr1      = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 7));
      raddr2      = ($urandom_range(0, 3) == 0) ? issue_rd : 5'($urandom_range(0, 31));
      #1;
      vectors++;
      if (rdata1 !== exp_rdata(raddr1) || rdata2 !== exp_rdata(raddr2)) begin
        miscompares++;
        $display("FAIL rand%0d_rdata: rdata1=%h rdata2=%h expected %h %h",
                 n, rdata1, rdata2, exp_rdata(raddr1), exp_rdata(raddr2));
      end
      vectors++;
      if (busy1 !== exp_busy(raddr1) || busy2 !== exp_busy(raddr2)) begin
        miscompares++;
        $display("FAIL rand%0d_busy: busy1=%b busy2=%b expected %b %b",
                 n, busy1, busy2, exp_busy(raddr1), exp_busy(raddr2));
      end
      vectors++;
      if (issue_full !== exp_full() || sb_err !== m_err) begin
        miscompares++;
        $display("FAIL rand%0d_full_err: full=%b sb_err=%b expected %b %b",
                 n, issue_full, sb_err, exp_full(), m_err);
      end
      tick();
    end
    set_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_bypass();
    test_x0();
    test_saturate();
    test_issue_wb_same();
    test_err_sticky();
    test_reset_priority();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
